// File: rtl/fc_result_collector_if.sv
// Score stream, result handshake and readback port of the result collector.
// master drives strobes/ack/address; slave is the collector.
interface fc_result_collector_if #(
    parameter int BIT   = 32,
    parameter int IDX_W = 3
);
    logic             data_ready_in;
    logic [BIT-1:0]   data_in;
    logic             result_ack;
    logic             result_valid;
    logic [IDX_W-1:0] class_idx;
    logic [BIT-1:0]   class_score;
    logic [IDX_W-1:0] score_rd_addr;
    logic [BIT-1:0]   score_rd_data;
    logic             overflow;

    modport master (
        output data_ready_in, data_in, result_ack, score_rd_addr,
        input  result_valid, class_idx, class_score,
        input  score_rd_data, overflow
    );

    modport slave (
        input  data_ready_in, data_in, result_ack, score_rd_addr,
        output result_valid, class_idx, class_score,
        output score_rd_data, overflow
    );
endinterface

// File: rtl/fc_result_collector.sv
// Final-layer result collector: running signed argmax, score buffer, held result.
// Optional macro FC_RESULT_RELU_EN clamps negative scores to 0 on input.
module fc_result_collector #(
    parameter int BIT     = 32,
    parameter int CLASSES = 6,
    parameter int IDX_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_,
    fc_result_collector_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] cnt;
    logic [BIT-1:0]   max_val;
    logic [IDX_W-1:0] max_idx;
    logic [BIT-1:0]   score_buf [CLASSES];
    logic [BIT-1:0]   score_in;
    logic             greater;
    logic             accept_first;
    logic             accept_next;
    logic             finish;
    logic             drop;
    logic             clear_valid;

    // Input conditioning: optional ReLU clamp ahead of storage and compare
`ifdef FC_RESULT_RELU_EN
    always_comb score_in = bus.data_in[BIT-1] ? '0 : bus.data_in;
`else
    always_comb score_in = bus.data_in;
`endif

    // Strictly greater keeps the lower index on ties
    always_comb greater = $signed(score_in) > $signed(max_val);

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and datapath control
    always_comb begin
        state_n      = state;
        accept_first = 1'b0;
        accept_next  = 1'b0;
        finish       = 1'b0;
        drop         = 1'b0;
        clear_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.data_ready_in) begin
                    accept_first = 1'b1;
                    state_n      = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.data_ready_in) begin
                    accept_next = 1'b1;
                    if (cnt == IDX_W'(CLASSES - 1)) begin
                        finish  = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.result_ack) begin
                    clear_valid = 1'b1;
                    if (bus.data_ready_in) begin
                        accept_first = 1'b1;
                        state_n      = COLLECT;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (bus.data_ready_in) begin
                    drop = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Running max, frame counter, result registers and sticky overflow
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt              <= '0;
            max_val          <= '0;
            max_idx          <= '0;
            bus.result_valid <= 1'b0;
            bus.class_idx    <= '0;
            bus.class_score  <= '0;
            bus.overflow     <= 1'b0;
        end else begin
            if (clear_valid) bus.result_valid <= 1'b0;
            if (drop)        bus.overflow     <= 1'b1;
            if (accept_first) begin
                max_val <= score_in;
                max_idx <= '0;
                cnt     <= IDX_W'(1);
            end
            if (accept_next) begin
                if (greater) begin
                    max_val <= score_in;
                    max_idx <= cnt;
                end
                if (finish) begin
                    bus.class_idx    <= greater ? cnt : max_idx;
                    bus.class_score  <= greater ? score_in : max_val;
                    bus.result_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Score buffer writes
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < CLASSES; i++) score_buf[i] <= '0;
        end else if (accept_first) begin
            score_buf[0] <= score_in;
        end else if (accept_next) begin
            score_buf[cnt] <= score_in;
        end
    end

    // Registered readback; out-of-range addresses read 0
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bus.score_rd_data <= '0;
        end else if (int'(bus.score_rd_addr) < CLASSES) begin
            bus.score_rd_data <= score_buf[bus.score_rd_addr];
        end else begin
            bus.score_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_fc_result_collector.sv
// Directed self-checking bench for fc_result_collector.
// Expectations follow FC_RESULT_RELU_EN when it is defined.
module tb_fc_result_collector;

    logic clk;
    logic rst_;
    int   checks;
    int   failures;

    fc_result_collector_if #(.BIT(32), .IDX_W(3)) bus ();

    fc_result_collector #(.BIT(32), .CLASSES(6), .IDX_W(3)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cl(input int v);
`ifdef FC_RESULT_RELU_EN
        return (v < 0) ? 32'd0 : 32'(v);
`else
        return 32'(v);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag,
                   $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v);
        bus.data_ready_in = 1'b1;
        bus.data_in       = 32'(v);
        tick();
        bus.data_ready_in = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input logic [31:0] exp);
        bus.score_rd_addr = 3'(a);
        tick();
        check(tag, bus.score_rd_data, exp);
    endtask

    int f1 [6] = '{5, -3, 40, 12, 40, 7};
    int f2 [6] = '{-9, -2, -7, -5, -4, -8};
    int g2 [6] = '{0, 1, 2, 3, 0, 1};
    int f4 [6] = '{1, 2, 3, 4, 200, 0};

    initial begin
        checks   = 0;
        failures = 0;
        rst_     = 1'b0;
        bus.data_ready_in = 1'b0;
        bus.data_in       = '0;
        bus.result_ack    = 1'b0;
        bus.score_rd_addr = '0;
        tick();
        tick();
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_idx",   32'(bus.class_idx),    32'd0);
        check("rst_score", bus.class_score,       32'd0);
        check("rst_rd",    bus.score_rd_data,     32'd0);
        check("rst_ovf",   32'(bus.overflow),     32'd0);
        rst_ = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) strobe(f1[i]);
        check("f1_not_yet", 32'(bus.result_valid), 32'd0);
        strobe(f1[5]);
        check("f1_valid", 32'(bus.result_valid), 32'd1);
        check("f1_idx",   32'(bus.class_idx),    32'd2);
        check("f1_score", bus.class_score,       32'd40);
        for (int a = 0; a < 6; a++) rd($sformatf("f1_rd%0d", a), a, cl(f1[a]));
        rd("f1_rd7", 7, 32'd0);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        check("f1_ack", 32'(bus.result_valid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            strobe(f2[i]);
            for (int g = 0; g < g2[i]; g++) tick();
        end
        check("f2_valid", 32'(bus.result_valid), 32'd1);
`ifdef FC_RESULT_RELU_EN
        check("f2_idx",   32'(bus.class_idx), 32'd0);
        check("f2_score", bus.class_score,    32'd0);
`else
        check("f2_idx",   32'(bus.class_idx), 32'd1);
        check("f2_score", bus.class_score,    32'hFFFF_FFFE);
`endif
        for (int i = 0; i < 5; i++) tick();
        check("hold_valid", 32'(bus.result_valid), 32'd1);
        strobe(77);
        strobe(88);
        check("hold_ovf",   32'(bus.overflow),  32'd1);
        check("hold_idx",   32'(bus.class_idx), cl(-2) == 0 ? 32'd0 : 32'd1);
        check("hold_score", bus.class_score,    cl(-2));
        rd("hold_rd0", 0, cl(-9));
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        check("f2_ack",  32'(bus.result_valid), 32'd0);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        for (int i = 0; i < 6; i++) strobe((i + 1) * 10);
        check("f3_idx",   32'(bus.class_idx), 32'd5);
        check("f3_score", bus.class_score,    32'd60);
        bus.result_ack = 1'b1;
        strobe(100);
        bus.result_ack = 1'b0;
        check("f4_ackd", 32'(bus.result_valid), 32'd0);
        for (int i = 0; i < 4; i++) strobe(f4[i]);
        check("f4_not_yet", 32'(bus.result_valid), 32'd0);
        strobe(f4[4]);
        check("f4_valid", 32'(bus.result_valid), 32'd1);
        check("f4_idx",   32'(bus.class_idx),    32'd5);
        check("f4_score", bus.class_score,       32'd200);
        rd("f4_rd0", 0, 32'd100);
        rd("f4_rd4", 4, 32'd4);

        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        strobe(50);
        strobe(60);
        strobe(70);
        rst_ = 1'b0;
        #2;
        check("mid_rst_valid", 32'(bus.result_valid), 32'd0);
        check("mid_rst_idx",   32'(bus.class_idx),    32'd0);
        check("mid_rst_score", bus.class_score,       32'd0);
        check("mid_rst_rd",    bus.score_rd_data,     32'd0);
        check("mid_rst_ovf",   32'(bus.overflow),     32'd0);
        tick();
        rst_ = 1'b1;
        tick();
        strobe(0);
        strobe(0);
        strobe(0);
        strobe(0);
        strobe(9);
        check("f5_not_yet", 32'(bus.result_valid), 32'd0);
        strobe(0);
        check("f5_valid", 32'(bus.result_valid), 32'd1);
        check("f5_idx",   32'(bus.class_idx),    32'd4);
        check("f5_score", bus.class_score,       32'd9);
        rd("f5_rd4", 4, 32'd9);
        rd("f5_rd2", 2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_result_collector.md
# fc_result_collector

Collects the class scores produced by the final fully-connected layer of the CNN inference pipeline and turns them into a registered classification result. Consumes the one-word-per-strobe output stream of the classifier (`data_out` qualified by `data_ready_out_fc`) and tracks the running maximum, so `class_idx` holds the winning class. Buffers all scores of a frame for host readback. Holds the result under a valid/ack handshake until the host consumes it.

## Interface

Parameters:
- `BIT`, 32: score width; two's-complement signed.
- `CLASSES`, 6: number of scores per frame. Legal range is 2..16.
- `IDX_W`, 3: width of class indices and addresses. Must satisfy `2**IDX_W >= CLASSES`.

Ports:
- `clk`, input, 1: clock. Single clock domain.
- `rst_`, input, 1: reset, asynchronous, active-low.
- `data_ready_in`, input, 1: score strobe. One score per high cycle; gaps are allowed.
- `data_in`, input, BIT: score value, sampled when `data_ready_in`=1.
- `result_ack`, input, 1: host consumes the result. Only meaningful while `result_valid`=1.
- `result_valid`, output, 1: a classification result is available.
- `class_idx`, output, IDX_W: index of the maximum score.
- `class_score`, output, BIT: value of the maximum score.
- `score_rd_addr`, input, IDX_W: readback address into the score buffer.
- `score_rd_data`, output, BIT: registered readback data.
- `overflow`, output, 1: sticky flag, set when a score is dropped.

## Operation

- Three states: IDLE, COLLECT, HOLD. Reset state is IDLE.
- IDLE:
  - On a strobe: store the score in `buf[0]`; `max_val`<=score; `max_idx`<=0; `cnt`<=1; go to COLLECT.
- COLLECT:
  - On a strobe: store the score in `buf[cnt]`.
  - If score > `max_val` (signed, strict), update `max_val` and `max_idx`<=cnt. On a tie, the lower index wins.
  - If `cnt`==CLASSES-1: load `class_idx` and `class_score` from the final max, including this score. Set `result_valid`<=1 and go to HOLD. Otherwise `cnt`<=cnt+1.
- HOLD:
  - `class_idx`, `class_score` and `buf` are frozen.
  - A strobe without `result_ack`: the score is dropped and `overflow`<=1.
  - `result_ack` without a strobe: `result_valid`<=0; go to IDLE.
  - `result_ack` and a strobe in the same cycle: the score is accepted as score 0 of the next frame, exactly as in IDLE. `result_valid`<=0; go to COLLECT. `buf[0]` is overwritten.
- `result_ack` outside HOLD is ignored.
- `overflow` is cleared only by reset.
- Readback:
  - `score_rd_data`<=`buf[score_rd_addr]` every cycle, in every state.
  - An address >= CLASSES reads 0.
  - During COLLECT, entries not yet written in the current frame return stale values from the previous frame.
- Arithmetic: comparison only, full BIT width, signed. No truncation.

## Timing

- Reset values: `result_valid`=0, `class_idx`=0, `class_score`=0, `score_rd_data`=0, `overflow`=0. `buf` entries=0, `cnt`=0, `max_*`=0.
- `result_valid` rises on the clock edge that samples the last score, i.e. it is visible 1 cycle after the last strobe cycle.
- `class_idx` and `class_score` are valid on the same edge as `result_valid`.
- `result_valid` falls on the edge that samples `result_ack`.
- Minimum frame time is CLASSES cycles of back-to-back strobes. With the host acking in the same cycle, throughput is one frame per CLASSES cycles with no bubble.
- Readback latency: 1 cycle from `score_rd_addr` to `score_rd_data`.
- Asserting `rst_` mid-frame aborts the frame immediately: all state returns to reset values and the partial frame is discarded.

## Configuration

- Macro `FC_RESULT_RELU_EN`.
- Defined: each incoming score is clamped to 0 if negative, before both storage and comparison. An all-negative frame therefore gives `class_idx`=0 and `class_score`=0.
- Undefined: scores are stored and compared unmodified as signed values.

## Test plan

- Back-to-back frame, scores 5,−3,40,12,40,7 → `result_valid` one cycle after the 6th strobe, `class_idx`=2, `class_score`=40. Readback addrs 0..5 return the inputs; addr 7 returns 0.
- Frame −9,−2,−7,−5,−4,−8 with gaps of 0..3 idle cycles between strobes:
  - macro undefined → `class_idx`=1, `class_score`=−2;
  - macro defined → `class_idx`=0, `class_score`=0.
- Result held 5 cycles, two strobes during HOLD without ack → both dropped, `overflow`=1, result unchanged. Ack → `result_valid`=0 next edge; `overflow` stays 1.
- Ack coincident with the first score (100) of frame 2, followed by 1,2,3,4,200 → frame 2 result `class_idx`=5, `class_score`=200, with no lost score.
- Reset pulsed after 3 of 6 scores, then a full frame 0,0,0,0,9,0 → `class_idx`=4. All outputs are 0 while reset is held.
